// File: rtl/adxl362_spi_slave.sv
// ADXL362-style SPI responder (mode 0) front-ending a byte-wide register bank.
// SCLK, MOSI and nCS are oversampled on clk_i; the design never runs on SCLK.
// Commands: 0x0A write register, 0x0B read register, 0x0D FIFO read.
module adxl362_spi_slave #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  FIFO_ADDR   = 8'h0D
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       sclk_i,
    input  logic       mosi_i,
    input  logic       ncs_i,
    output logic       miso_o,
    output logic       miso_oe_o,
    output logic [7:0] reg_addr_o,
    output logic [7:0] reg_wdata_o,
    output logic       reg_we_o,
    output logic       reg_re_o,
    input  logic [7:0] reg_rdata_i,
    output logic       busy_o,
    output logic       cmd_err_o
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CMD    = 3'd1;
    localparam logic [2:0] ADDR   = 3'd2;
    localparam logic [2:0] WDATA  = 3'd3;
    localparam logic [2:0] RDATA  = 3'd4;
    localparam logic [2:0] IGNORE = 3'd5;

    localparam logic [7:0] CMD_WRITE = 8'h0A;
    localparam logic [7:0] CMD_READ  = 8'h0B;
    localparam logic [7:0] CMD_FIFO  = 8'h0D;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] ncs_sync;
    logic                   sclk_q;
    logic                   ncs_q;

    logic                   sclk_s;
    logic                   mosi_s;
    logic                   ncs_s;
    logic                   sclk_rise;
    logic                   sclk_fall;
    logic                   ncs_rise;
    logic                   ncs_fall;

    logic [2:0]             state;
    logic [2:0]             bit_cnt;
    logic [7:0]             rx_shift;
    logic [7:0]             tx_shift;
    logic [7:0]             addr;
    logic                   is_write;
    logic                   is_fifo;
    logic                   rd_load;
    logic [7:0]             rx_byte;
    logic                   byte_done;

    // Synchronize the SPI pins and keep one extra delayed copy for edge detection.
    // nCS resets high so releasing reset never looks like a chip-select edge.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            ncs_sync  <= '1;
            sclk_q    <= 1'b0;
            ncs_q     <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs_i};
            sclk_q    <= sclk_sync[SYNC_STAGES-1];
            ncs_q     <= ncs_sync[SYNC_STAGES-1];
        end
    end

    // Edge strobes and the byte assembled on the current rising edge.
    always_comb begin
        sclk_s    = sclk_sync[SYNC_STAGES-1];
        mosi_s    = mosi_sync[SYNC_STAGES-1];
        ncs_s     = ncs_sync[SYNC_STAGES-1];
        sclk_rise = sclk_s & ~sclk_q;
        sclk_fall = ~sclk_s & sclk_q;
        ncs_rise  = ncs_s & ~ncs_q;
        ncs_fall  = ~ncs_s & ncs_q;
        rx_byte   = {rx_shift[6:0], mosi_s};
        byte_done = sclk_rise && (bit_cnt == 3'd7);
    end

    // Protocol FSM, shift registers and register-bank strobes.
    // Read data is loaded one cycle after reg_re_o; the next SCLK fall then puts
    // its MSB on MISO ahead of the first rising edge of the data byte.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            addr        <= '0;
            is_write    <= 1'b0;
            is_fifo     <= 1'b0;
            rd_load     <= 1'b0;
            miso_o      <= 1'b0;
            reg_addr_o  <= '0;
            reg_wdata_o <= '0;
            reg_we_o    <= 1'b0;
            reg_re_o    <= 1'b0;
            cmd_err_o   <= 1'b0;
        end else begin
            reg_we_o  <= 1'b0;
            reg_re_o  <= 1'b0;
            cmd_err_o <= 1'b0;
            rd_load   <= reg_re_o;
            if (ncs_rise) begin
                state    <= IDLE;
                bit_cnt  <= '0;
                rx_shift <= '0;
                tx_shift <= '0;
                addr     <= '0;
                is_write <= 1'b0;
                is_fifo  <= 1'b0;
                rd_load  <= 1'b0;
                miso_o   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (ncs_fall) begin
                            state    <= CMD;
                            bit_cnt  <= '0;
                            rx_shift <= '0;
                            is_write <= 1'b0;
                            is_fifo  <= 1'b0;
                        end
                    end
                    default: begin
                        if (sclk_rise) begin
                            bit_cnt  <= bit_cnt + 3'd1;
                            rx_shift <= rx_byte;
                        end
                        if (byte_done) begin
                            case (state)
                                CMD: begin
                                    if (rx_byte == CMD_WRITE) begin
                                        is_write <= 1'b1;
                                        state    <= ADDR;
                                    end else if (rx_byte == CMD_READ) begin
                                        is_write <= 1'b0;
                                        state    <= ADDR;
                                    end else if (rx_byte == CMD_FIFO) begin
                                        is_fifo    <= 1'b1;
                                        addr       <= FIFO_ADDR;
                                        reg_addr_o <= FIFO_ADDR;
                                        reg_re_o   <= 1'b1;
                                        state      <= RDATA;
                                    end else begin
                                        cmd_err_o <= 1'b1;
                                        state     <= IGNORE;
                                    end
                                end
                                ADDR: begin
                                    if (is_write) begin
                                        addr  <= rx_byte;
                                        state <= WDATA;
                                    end else begin
                                        reg_addr_o <= rx_byte;
                                        reg_re_o   <= 1'b1;
                                        addr       <= rx_byte + 8'd1;
                                        state      <= RDATA;
                                    end
                                end
                                WDATA: begin
                                    reg_addr_o  <= addr;
                                    reg_wdata_o <= rx_byte;
                                    reg_we_o    <= 1'b1;
                                    addr        <= addr + 8'd1;
                                end
                                RDATA: begin
                                    reg_addr_o <= addr;
                                    reg_re_o   <= 1'b1;
                                    if (!is_fifo) begin
                                        addr <= addr + 8'd1;
                                    end
                                end
                                default: begin
                                end
                            endcase
                        end
                    end
                endcase
                if ((state == RDATA) && sclk_fall) begin
                    miso_o   <= tx_shift[7];
                    tx_shift <= {tx_shift[6:0], 1'b0};
                end
                if (rd_load) begin
                    tx_shift <= reg_rdata_i;
                end
            end
        end
    end

    // Status and MISO tristate control follow the FSM state directly.
    always_comb begin
        busy_o    = (state != IDLE);
        miso_oe_o = (state == RDATA);
    end

endmodule

// File: tb/tb_adxl362_spi_slave.sv
// Directed bench for adxl362_spi_slave acting as an SPI mode-0 master with a
// behavioural register bank (registered read, FIFO port at 0x0D).
`timescale 1ns/1ps
module tb_adxl362_spi_slave;

    localparam int H = 8;

    logic       clk;
    logic       rst_n;
    logic       sclk;
    logic       mosi;
    logic       ncs;
    logic       miso;
    logic       miso_oe;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic       busy;
    logic       cmd_err;

    int checks;
    int failures;

    int we_cnt;
    int re_cnt;
    int err_cnt;
    int oe_cnt;
    int both_cnt;
    logic [7:0] we_addr [64];
    logic [7:0] we_data [64];
    logic [7:0] re_addr [64];

    logic [7:0] mem [256];
    int         fifo_idx;

    adxl362_spi_slave #(.SYNC_STAGES(2), .FIFO_ADDR(8'h0D)) dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .sclk_i      (sclk),
        .mosi_i      (mosi),
        .ncs_i       (ncs),
        .miso_o      (miso),
        .miso_oe_o   (miso_oe),
        .reg_addr_o  (reg_addr),
        .reg_wdata_o (reg_wdata),
        .reg_we_o    (reg_we),
        .reg_re_o    (reg_re),
        .reg_rdata_i (reg_rdata),
        .busy_o      (busy),
        .cmd_err_o   (cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] fifo_val(input int idx);
        case (idx)
            0: fifo_val = 8'h5A;
            1: fifo_val = 8'hA5;
            default: fifo_val = 8'h00;
        endcase
    endfunction

    // Register bank: synchronous write, read data valid the cycle after reg_re.
    always @(posedge clk) begin
        if (reg_we) mem[reg_addr] <= reg_wdata;
        if (reg_re) begin
            if (reg_addr == 8'h0D) begin
                reg_rdata <= fifo_val(fifo_idx);
                fifo_idx  <= fifo_idx + 1;
            end else begin
                reg_rdata <= mem[reg_addr];
            end
        end
    end

    // Strobe monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (reg_we) begin
            if (we_cnt < 64) begin
                we_addr[we_cnt] = reg_addr;
                we_data[we_cnt] = reg_wdata;
            end
            we_cnt++;
        end
        if (reg_re) begin
            if (re_cnt < 64) re_addr[re_cnt] = reg_addr;
            re_cnt++;
        end
        if (cmd_err) err_cnt++;
        if (miso_oe) oe_cnt++;
        if (reg_we && reg_re) both_cnt++;
    end

    task automatic cs_low();
        @(negedge clk);
        ncs = 1'b0;
        repeat (H) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (H) @(negedge clk);
        ncs = 1'b1;
        repeat (3 * H) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = '0;
        for (int i = 7; i > 7 - n; i--) begin
            @(negedge clk);
            mosi = tx[i];
            repeat (H) @(negedge clk);
            rx[i] = miso;
            sclk = 1'b1;
            repeat (H) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        spi_bits(tx, 8, rx);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ncs   = 1'b1;
        sclk  = 1'b0;
        mosi  = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", busy); end
        checks++; if (miso !== 1'b0 || miso_oe !== 1'b0) begin failures++; $display("FAIL reset_miso got=%0h/%0h exp=0/0", miso, miso_oe); end
        checks++; if (reg_we !== 1'b0 || reg_re !== 1'b0 || cmd_err !== 1'b0) begin failures++; $display("FAIL reset_strobes got=%0h%0h%0h exp=000", reg_we, reg_re, cmd_err); end
        checks++; if (reg_addr !== 8'h00 || reg_wdata !== 8'h00) begin failures++; $display("FAIL reset_bus got=%0h/%0h exp=00/00", reg_addr, reg_wdata); end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_write();
        logic [7:0] rx;
        int wb = we_cnt;
        int rb = re_cnt;
        cs_low();
        spi_byte(8'h0A, rx);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL write_busy_mid got=%0h exp=1", busy); end
        spi_byte(8'h2D, rx);
        spi_byte(8'h02, rx);
        cs_high();
        checks++; if (we_cnt - wb !== 1) begin failures++; $display("FAIL write_we_count got=%0d exp=1", we_cnt - wb); end
        checks++; if (we_addr[wb] !== 8'h2D || we_data[wb] !== 8'h02) begin failures++; $display("FAIL write_we_payload got=%0h/%0h exp=2d/02", we_addr[wb], we_data[wb]); end
        checks++; if (re_cnt - rb !== 0) begin failures++; $display("FAIL write_no_re got=%0d exp=0", re_cnt - rb); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL write_busy_end got=%0h exp=0", busy); end
    endtask

    task automatic test_write_burst();
        logic [7:0] rx;
        int wb = we_cnt;
        cs_low();
        spi_byte(8'h0A, rx);
        spi_byte(8'h00, rx);
        spi_byte(8'hAD, rx);
        spi_byte(8'h1D, rx);
        spi_byte(8'hF2, rx);
        cs_high();
        checks++; if (we_cnt - wb !== 3) begin failures++; $display("FAIL burst_we_count got=%0d exp=3", we_cnt - wb); end
        checks++; if (mem[0] !== 8'hAD || mem[1] !== 8'h1D || mem[2] !== 8'hF2) begin failures++; $display("FAIL burst_mem got=%0h %0h %0h exp=ad 1d f2", mem[0], mem[1], mem[2]); end
    endtask

    task automatic test_read();
        logic [7:0] rx;
        logic [7:0] exp_data [3];
        int rb = re_cnt;
        int wb = we_cnt;
        int ob = oe_cnt;
        exp_data[0] = 8'hAD;
        exp_data[1] = 8'h1D;
        exp_data[2] = 8'hF2;
        cs_low();
        spi_byte(8'h0B, rx);
        spi_byte(8'h00, rx);
        for (int k = 0; k < 3; k++) begin
            spi_byte(8'h00, rx);
            checks++; if (rx !== exp_data[k]) begin failures++; $display("FAIL read_miso[%0d] got=%0h exp=%0h", k, rx, exp_data[k]); end
        end
        cs_high();
        checks++; if (re_cnt - rb !== 4) begin failures++; $display("FAIL read_re_count got=%0d exp=4", re_cnt - rb); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (re_addr[rb + k] !== 8'(k)) begin failures++; $display("FAIL read_re_addr[%0d] got=%0h exp=%0h", k, re_addr[rb + k], k); end
        end
        checks++; if (we_cnt - wb !== 0) begin failures++; $display("FAIL read_no_we got=%0d exp=0", we_cnt - wb); end
        checks++; if (oe_cnt - ob < 3 * 16 * H) begin failures++; $display("FAIL read_oe_cycles got=%0d exp>=%0d", oe_cnt - ob, 3 * 16 * H); end
        checks++; if (miso_oe !== 1'b0 || miso !== 1'b0) begin failures++; $display("FAIL read_release got=%0h/%0h exp=0/0", miso_oe, miso); end
    endtask

    task automatic test_write_wrap();
        logic [7:0] rx;
        int wb = we_cnt;
        cs_low();
        spi_byte(8'h0A, rx);
        spi_byte(8'hFF, rx);
        spi_byte(8'h11, rx);
        spi_byte(8'h22, rx);
        cs_high();
        checks++; if (we_cnt - wb !== 2) begin failures++; $display("FAIL wrap_we_count got=%0d exp=2", we_cnt - wb); end
        checks++; if (we_addr[wb] !== 8'hFF || we_data[wb] !== 8'h11) begin failures++; $display("FAIL wrap_first got=%0h/%0h exp=ff/11", we_addr[wb], we_data[wb]); end
        checks++; if (we_addr[wb + 1] !== 8'h00 || we_data[wb + 1] !== 8'h22) begin failures++; $display("FAIL wrap_second got=%0h/%0h exp=00/22", we_addr[wb + 1], we_data[wb + 1]); end
    endtask

    task automatic test_fifo();
        logic [7:0] rx0;
        logic [7:0] rx1;
        int rb = re_cnt;
        cs_low();
        spi_byte(8'h0D, rx0);
        spi_byte(8'h00, rx0);
        spi_byte(8'h00, rx1);
        cs_high();
        checks++; if (rx0 !== 8'h5A) begin failures++; $display("FAIL fifo_miso0 got=%0h exp=5a", rx0); end
        checks++; if (rx1 !== 8'hA5) begin failures++; $display("FAIL fifo_miso1 got=%0h exp=a5", rx1); end
        checks++; if (re_cnt - rb !== 3) begin failures++; $display("FAIL fifo_re_count got=%0d exp=3", re_cnt - rb); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (re_addr[rb + k] !== 8'h0D) begin failures++; $display("FAIL fifo_re_addr[%0d] got=%0h exp=0d", k, re_addr[rb + k]); end
        end
    endtask

    task automatic test_ignore();
        logic [7:0] rx0;
        logic [7:0] rx1;
        int wb = we_cnt;
        int rb = re_cnt;
        int eb = err_cnt;
        int ob = oe_cnt;
        cs_low();
        spi_byte(8'h55, rx0);
        spi_byte(8'hA5, rx0);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ignore_busy got=%0h exp=1", busy); end
        spi_byte(8'h3C, rx1);
        cs_high();
        checks++; if (err_cnt - eb !== 1) begin failures++; $display("FAIL ignore_err_cycles got=%0d exp=1", err_cnt - eb); end
        checks++; if (we_cnt - wb !== 0 || re_cnt - rb !== 0) begin failures++; $display("FAIL ignore_strobes got=%0d/%0d exp=0/0", we_cnt - wb, re_cnt - rb); end
        checks++; if (oe_cnt - ob !== 0) begin failures++; $display("FAIL ignore_oe got=%0d exp=0", oe_cnt - ob); end
        checks++; if (rx0 !== 8'h00 || rx1 !== 8'h00) begin failures++; $display("FAIL ignore_miso got=%0h/%0h exp=00/00", rx0, rx1); end
    endtask

    task automatic test_abort();
        logic [7:0] rx;
        int wb;
        int rb;
        cs_low();
        spi_byte(8'h0A, rx);
        spi_byte(8'h10, rx);
        spi_byte(8'h3C, rx);
        cs_high();
        wb = we_cnt;
        cs_low();
        spi_byte(8'h0A, rx);
        spi_byte(8'h10, rx);
        spi_bits(8'hF0, 4, rx);
        cs_high();
        checks++; if (we_cnt - wb !== 0) begin failures++; $display("FAIL abort_no_we got=%0d exp=0", we_cnt - wb); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%0h exp=0", busy); end
        rb = re_cnt;
        cs_low();
        spi_byte(8'h0B, rx);
        spi_byte(8'h10, rx);
        spi_byte(8'h00, rx);
        cs_high();
        checks++; if (rx !== 8'h3C) begin failures++; $display("FAIL abort_readback got=%0h exp=3c", rx); end
        checks++; if (re_cnt - rb !== 2 || re_addr[rb] !== 8'h10 || re_addr[rb + 1] !== 8'h11) begin failures++; $display("FAIL abort_read_re got=%0d %0h %0h exp=2 10 11", re_cnt - rb, re_addr[rb], re_addr[rb + 1]); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] rx;
        int wb = we_cnt;
        int rb = re_cnt;
        cs_low();
        spi_byte(8'h0B, rx);
        spi_byte(8'h02, rx);
        spi_bits(8'h00, 3, rx);
        checks++; if (miso_oe !== 1'b1 || miso !== 1'b1) begin failures++; $display("FAIL rstmid_pre got=%0h/%0h exp=1/1", miso_oe, miso); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (miso_oe !== 1'b0 || miso !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_outputs got=%0h/%0h/%0h exp=0/0/0", miso_oe, miso, busy); end
        checks++; if (reg_addr !== 8'h00 || reg_re !== 1'b0 || reg_we !== 1'b0) begin failures++; $display("FAIL rstmid_bus got=%0h/%0h/%0h exp=00/0/0", reg_addr, reg_re, reg_we); end
        ncs  = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4 * H) @(negedge clk);
        checks++; if (we_cnt - wb !== 0 || re_cnt - rb !== 1) begin failures++; $display("FAIL rstmid_strobes got=%0d/%0d exp=0/1", we_cnt - wb, re_cnt - rb); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        we_cnt   = 0;
        re_cnt   = 0;
        err_cnt  = 0;
        oe_cnt   = 0;
        both_cnt = 0;
        fifo_idx = 0;
        test_reset();
        test_write();
        test_write_burst();
        test_read();
        test_write_wrap();
        test_fifo();
        test_ignore();
        test_abort();
        test_reset_mid();
        checks++; if (both_cnt !== 0) begin failures++; $display("FAIL strobe_overlap got=%0d exp=0", both_cnt); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
